// File: rtl/sd_init_sequencer.sv
// SD card power-up sequencer: drives the command-line controller through
// CMD0, CMD8, CMD55/ACMD41, CMD2, CMD3, CMD7 and (SDSC only) CMD16.
module sd_init_sequencer #(
  parameter logic [15:0] SLOW_CLKDIV    = 16'd124,
  parameter logic [15:0] FAST_CLKDIV    = 16'd1,
  parameter logic [15:0] INIT_PRECYCLES = 16'd80,
  parameter logic [15:0] ACMD41_TRIES   = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_start,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_err,
  output logic [3:0]  err_code,
  output logic        card_hc,
  output logic [15:0] rca,
  output logic        cmd_start,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  output logic [15:0] cmd_clkdiv,
  output logic [15:0] cmd_precycles,
  input  logic [31:0] cmd_resparg,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic        cmd_syntaxerr
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE, ERROR} state_t;
  typedef enum logic [2:0] {
    S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3, S_CMD7, S_CMD16
  } step_t;

  state_t      state;
  step_t       step;
  logic        hc_allowed;
  logic [15:0] retry_cnt;
  logic        rsp_timeout;
  logic        rsp_synerr;
  logic [15:0] rsp_hi;
  logic [11:0] rsp_lo;

  // Response bits [15:12] carry nothing the sequence needs.
  logic unused_resp_bits;
  assign unused_resp_bits = &{1'b0, cmd_resparg[15:12]};

  function automatic logic [5:0] step_idx(input step_t s);
    case (s)
      S_CMD0:   step_idx = 6'd0;
      S_CMD8:   step_idx = 6'd8;
      S_CMD55:  step_idx = 6'd55;
      S_ACMD41: step_idx = 6'd41;
      S_CMD2:   step_idx = 6'd2;
      S_CMD3:   step_idx = 6'd3;
      S_CMD7:   step_idx = 6'd7;
      default:  step_idx = 6'd16;
    endcase
  endfunction

  function automatic logic [31:0] step_arg(input step_t s, input logic hc,
                                           input logic [15:0] r);
    case (s)
      S_CMD8:   step_arg = 32'h0000_01AA;
      S_ACMD41: step_arg = {1'b0, hc, 6'b0, 24'hFF8000};
      S_CMD7:   step_arg = {r, 16'h0000};
      S_CMD16:  step_arg = 32'd512;
      default:  step_arg = 32'h0;
    endcase
  endfunction

  logic        ev_fail;
  logic        ev_finish;
  logic [3:0]  ev_code;
  step_t       ev_next;
  logic        ev_hc_allowed;
  logic        ev_card_hc;
  logic [15:0] ev_rca;
  logic [15:0] ev_retry;
  logic [15:0] retry_inc;

  assign retry_inc = (retry_cnt == 16'hFFFF) ? retry_cnt : retry_cnt + 16'd1;

  always_comb begin
    ev_fail       = 1'b0;
    ev_finish     = 1'b0;
    ev_code       = 4'd0;
    ev_next       = step;
    ev_hc_allowed = hc_allowed;
    ev_card_hc    = card_hc;
    ev_rca        = rca;
    ev_retry      = retry_cnt;
    case (step)
      S_CMD0: ev_next = S_CMD8;
      S_CMD8: begin
        if (rsp_timeout) begin
          ev_hc_allowed = 1'b0;
          ev_next       = S_CMD55;
        end else if (rsp_lo == 12'h1AA) begin
          ev_hc_allowed = 1'b1;
          ev_next       = S_CMD55;
        end else begin
          ev_fail = 1'b1;
          ev_code = 4'd1;
        end
      end
      S_CMD55: begin
        if (rsp_timeout || rsp_synerr) begin
          ev_fail = 1'b1;
          ev_code = 4'd2;
        end else begin
          ev_next = S_ACMD41;
        end
      end
      // R3 carries no valid CRC, so syntax errors are not meaningful here.
      S_ACMD41: begin
        if (rsp_timeout) begin
          ev_fail = 1'b1;
          ev_code = 4'd3;
        end else if (rsp_hi[15]) begin
          ev_card_hc = rsp_hi[14] & hc_allowed;
          ev_next    = S_CMD2;
        end else begin
          ev_retry = retry_inc;
          if (retry_inc == ACMD41_TRIES) begin
            ev_fail = 1'b1;
            ev_code = 4'd4;
          end else begin
            ev_next = S_CMD55;
          end
        end
      end
      S_CMD2: begin
        if (rsp_timeout) begin
          ev_fail = 1'b1;
          ev_code = 4'd5;
        end else begin
          ev_next = S_CMD3;
        end
      end
      S_CMD3: begin
        if (rsp_timeout) begin
          ev_fail = 1'b1;
          ev_code = 4'd6;
        end else begin
          ev_rca  = rsp_hi;
          ev_next = S_CMD7;
        end
      end
      S_CMD7: begin
        if (rsp_timeout || rsp_synerr) begin
          ev_fail = 1'b1;
          ev_code = 4'd7;
        end else if (card_hc) begin
          ev_finish = 1'b1;
        end else begin
          ev_next = S_CMD16;
        end
      end
      default: begin
        if (rsp_timeout || rsp_synerr) begin
          ev_fail = 1'b1;
          ev_code = 4'd8;
        end else begin
          ev_finish = 1'b1;
        end
      end
    endcase
  end

  // Command outputs are loaded on ISSUE entry and left untouched until the
  // next ISSUE entry, which keeps them stable across the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      step          <= S_CMD0;
      hc_allowed    <= 1'b0;
      retry_cnt     <= 16'd0;
      rsp_timeout   <= 1'b0;
      rsp_synerr    <= 1'b0;
      rsp_hi        <= 16'd0;
      rsp_lo        <= 12'd0;
      init_busy     <= 1'b0;
      init_done     <= 1'b0;
      init_err      <= 1'b0;
      err_code      <= 4'd0;
      card_hc       <= 1'b0;
      rca           <= 16'd0;
      cmd_start     <= 1'b0;
      cmd_idx       <= 6'd0;
      cmd_arg       <= 32'd0;
      cmd_clkdiv    <= SLOW_CLKDIV;
      cmd_precycles <= 16'd0;
    end else begin
      cmd_start <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (init_start) begin
            init_done     <= 1'b0;
            init_err      <= 1'b0;
            err_code      <= 4'd0;
            card_hc       <= 1'b0;
            rca           <= 16'd0;
            retry_cnt     <= 16'd0;
            hc_allowed    <= 1'b0;
            step          <= S_CMD0;
            cmd_clkdiv    <= SLOW_CLKDIV;
            cmd_idx       <= step_idx(S_CMD0);
            cmd_arg       <= 32'd0;
            cmd_precycles <= INIT_PRECYCLES;
            init_busy     <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!cmd_busy) begin
            cmd_start <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cmd_done) begin
            rsp_timeout <= cmd_timeout;
            rsp_synerr  <= cmd_syntaxerr;
            rsp_hi      <= cmd_resparg[31:16];
            rsp_lo      <= cmd_resparg[11:0];
            state       <= EVAL;
          end
        end
        EVAL: begin
          retry_cnt  <= ev_retry;
          hc_allowed <= ev_hc_allowed;
          card_hc    <= ev_card_hc;
          rca        <= ev_rca;
          if (ev_fail) begin
            err_code  <= ev_code;
            init_err  <= 1'b1;
            init_busy <= 1'b0;
            state     <= ERROR;
          end else if (ev_finish) begin
            init_done <= 1'b1;
            init_busy <= 1'b0;
            state     <= DONE;
          end else begin
            step          <= ev_next;
            cmd_idx       <= step_idx(ev_next);
            cmd_arg       <= step_arg(ev_next, ev_hc_allowed, ev_rca);
            cmd_precycles <= 16'd0;
            if (ev_next == S_CMD7) cmd_clkdiv <= FAST_CLKDIV;
            state         <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer with a behavioural command-controller
// responder that logs every issued command.
module tb_sd_init_sequencer;

  localparam int RSP_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_start = 1'b0;
  logic        init_busy, init_done, init_err, card_hc, cmd_start;
  logic [3:0]  err_code;
  logic [15:0] rca, cmd_clkdiv, cmd_precycles;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [31:0] cmd_resparg = 32'd0;
  logic        cmd_busy = 1'b0;
  logic        cmd_done = 1'b0;
  logic        cmd_timeout = 1'b0;
  logic        cmd_syntaxerr = 1'b0;

  int total = 0;
  int bad = 0;

  // Card model controls: 0 SDHC, 1 v1, 2 bad CMD8 echo, 3 never ready
  int card_type = 0;
  int ready_after = 0;
  int busy_extra = 0;
  int scenario_id = 0;

  logic [5:0]  log_idx[$];
  logic [31:0] log_arg[$];
  logic [15:0] log_pre[$];
  logic [15:0] log_div[$];

  sd_init_sequencer #(
    .SLOW_CLKDIV(16'd124), .FAST_CLKDIV(16'd1),
    .INIT_PRECYCLES(16'd80), .ACMD41_TRIES(16'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done), .init_err(init_err),
    .err_code(err_code), .card_hc(card_hc), .rca(rca),
    .cmd_start(cmd_start), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .cmd_clkdiv(cmd_clkdiv), .cmd_precycles(cmd_precycles),
    .cmd_resparg(cmd_resparg), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .cmd_timeout(cmd_timeout), .cmd_syntaxerr(cmd_syntaxerr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
  endtask

  task automatic waitEnd(input int budget);
    int   n = 0;
    logic prev_busy = init_busy;
    while (!(init_done || init_err) && n < budget) begin
      prev_busy = init_busy;
      @(negedge clk);
      n++;
    end
    checkOutput("end_reached", 32'(n < budget), 32'd1);
    checkOutput("busy_falls_with_flag", {30'd0, prev_busy, init_busy}, 32'd2);
  endtask

  function automatic int count41();
    int c = 0;
    for (int i = 0; i < log_idx.size(); i++) if (log_idx[i] == 6'd41) c++;
    return c;
  endfunction

  // Controller model: busy from the start pulse until one clk past done
  int   phase = 0;
  int   cnt = 0;
  int   hold = 0;
  int   cur_id = -1;
  int   acmd_n = 0;
  logic first_after_done = 1'b0;
  logic [5:0]  cur_idx = 6'd0;
  logic [31:0] cur_arg = 32'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cmd_busy = 1'b0;
      cmd_done = 1'b0;
      cmd_timeout = 1'b0;
      cmd_syntaxerr = 1'b0;
      phase = 0;
    end else begin
      if (scenario_id != cur_id) begin
        log_idx.delete(); log_arg.delete(); log_pre.delete(); log_div.delete();
        acmd_n = 0;
        cur_id = scenario_id;
      end
      case (phase)
        0: if (cmd_start) begin
          log_idx.push_back(cmd_idx);
          log_arg.push_back(cmd_arg);
          log_pre.push_back(cmd_precycles);
          log_div.push_back(cmd_clkdiv);
          cur_idx = cmd_idx;
          cur_arg = cmd_arg;
          cmd_busy = 1'b1;
          cnt = RSP_LAT;
          phase = 1;
        end
        1: begin
          checkOutput("start_while_busy", {31'd0, cmd_start}, 32'd0);
          cnt--;
          if (cnt == 0) begin
            cmd_timeout = 1'b0;
            cmd_syntaxerr = 1'b0;
            cmd_resparg = 32'd0;
            case (cur_idx)
              6'd0: cmd_timeout = 1'b1;
              6'd8: begin
                if (card_type == 1) cmd_timeout = 1'b1;
                else if (card_type == 2) cmd_resparg = 32'h0000_0155;
                else cmd_resparg = 32'h0000_01AA;
              end
              6'd55: cmd_resparg = 32'h0000_0120;
              6'd41: begin
                cmd_syntaxerr = 1'b1;
                cmd_resparg = (acmd_n < ready_after) ? 32'h00FF_8000 : 32'hC0FF_8000;
                acmd_n++;
              end
              6'd3: cmd_resparg = 32'h1234_0500;
              default: cmd_resparg = 32'd0;
            endcase
            cmd_done = 1'b1;
            first_after_done = 1'b1;
            hold = 1 + busy_extra;
            phase = 2;
          end
        end
        default: begin
          checkOutput("start_while_busy", {31'd0, cmd_start}, 32'd0);
          if (first_after_done) begin
            checkOutput("idx_stable", {26'd0, cmd_idx}, {26'd0, cur_idx});
            checkOutput("arg_stable", cmd_arg, cur_arg);
            first_after_done = 1'b0;
          end
          cmd_done = 1'b0;
          cmd_timeout = 1'b0;
          cmd_syntaxerr = 1'b0;
          hold--;
          if (hold == 0) begin
            cmd_busy = 1'b0;
            phase = 0;
          end
        end
      endcase
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_flags", {27'd0, init_busy, init_done, init_err, cmd_start, card_hc}, 32'd0);
    checkOutput("rst_err_code", {28'd0, err_code}, 32'd0);
    checkOutput("rst_rca", {16'd0, rca}, 32'd0);
    checkOutput("rst_idx", {26'd0, cmd_idx}, 32'd0);
    checkOutput("rst_arg", cmd_arg, 32'd0);
    checkOutput("rst_clkdiv", {16'd0, cmd_clkdiv}, 32'd124);
    checkOutput("rst_pre", {16'd0, cmd_precycles}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SDHC card: two not-ready ACMD41 replies, then ready with CCS
    card_type = 0; ready_after = 2; busy_extra = 0; scenario_id = 1;
    @(negedge clk);
    applyStimulus();
    checkOutput("hc_busy_rise", {31'd0, init_busy}, 32'd1);
    checkOutput("hc_cmd0_pre", {16'd0, cmd_precycles}, 32'd80);
    waitEnd(2000);
    checkOutput("hc_done", {30'd0, init_done, init_err}, 32'd2);
    checkOutput("hc_card_hc", {31'd0, card_hc}, 32'd1);
    checkOutput("hc_rca", {16'd0, rca}, 32'h1234);
    checkOutput("hc_ncmds", log_idx.size(), 32'd11);
    checkOutput("hc_cmd8_arg", log_arg[1], 32'h1AA);
    checkOutput("hc_cmd8_pre", {16'd0, log_pre[1]}, 32'd0);
    checkOutput("hc_acmd41_arg", log_arg[3], 32'h40FF_8000);
    checkOutput("hc_cmd3_div", {16'd0, log_div[9]}, 32'd124);
    checkOutput("hc_cmd7_idx", {26'd0, log_idx[10]}, 32'd7);
    checkOutput("hc_cmd7_arg", log_arg[10], 32'h1234_0000);
    checkOutput("hc_cmd7_div", {16'd0, log_div[10]}, 32'd1);

    // v1 card: CMD8 silent, ACMD41 ready immediately with bit30 set
    card_type = 1; ready_after = 0; scenario_id = 2;
    @(negedge clk);
    applyStimulus();
    waitEnd(2000);
    checkOutput("v1_done", {30'd0, init_done, init_err}, 32'd2);
    checkOutput("v1_card_hc", {31'd0, card_hc}, 32'd0);
    checkOutput("v1_ncmds", log_idx.size(), 32'd8);
    checkOutput("v1_acmd41_arg", log_arg[3], 32'h00FF_8000);
    checkOutput("v1_cmd16_idx", {26'd0, log_idx[7]}, 32'd16);
    checkOutput("v1_cmd16_arg", log_arg[7], 32'd512);

    // Bad CMD8 echo aborts with code 1 and issues nothing more
    card_type = 2; scenario_id = 3;
    @(negedge clk);
    applyStimulus();
    waitEnd(2000);
    checkOutput("echo_err", {30'd0, init_done, init_err}, 32'd1);
    checkOutput("echo_code", {28'd0, err_code}, 32'd1);
    repeat (30) @(negedge clk);
    checkOutput("echo_ncmds", log_idx.size(), 32'd2);

    // Card never ready: exactly three CMD55/ACMD41 pairs, then code 4
    card_type = 3; ready_after = 1000; scenario_id = 4;
    @(negedge clk);
    applyStimulus();
    waitEnd(2000);
    checkOutput("nr_code", {28'd0, err_code}, 32'd4);
    checkOutput("nr_ncmds", log_idx.size(), 32'd8);
    checkOutput("nr_n41", count41(), 32'd3);

    // Controller holds busy five extra cycles after each done
    card_type = 0; ready_after = 2; busy_extra = 5; scenario_id = 5;
    @(negedge clk);
    applyStimulus();
    checkOutput("bx_flags_cleared", {30'd0, init_err, init_done}, 32'd0);
    checkOutput("bx_code_cleared", {28'd0, err_code}, 32'd0);
    waitEnd(3000);
    checkOutput("bx_done", {30'd0, init_done, init_err}, 32'd2);
    checkOutput("bx_ncmds", log_idx.size(), 32'd11);
    checkOutput("bx_rca", {16'd0, rca}, 32'h1234);

    // Asynchronous reset in the middle of the ACMD41 loop
    card_type = 3; ready_after = 1000; busy_extra = 0; scenario_id = 6;
    @(negedge clk);
    applyStimulus();
    for (int n = 0; n < 500 && count41() < 2; n++) @(negedge clk);
    checkOutput("rs_in_loop", 32'(count41() >= 2), 32'd1);
    checkOutput("rs_busy_before", {31'd0, init_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rs_flags", {27'd0, init_busy, init_done, init_err, cmd_start, card_hc}, 32'd0);
    checkOutput("rs_idx", {26'd0, cmd_idx}, 32'd0);
    checkOutput("rs_arg", cmd_arg, 32'd0);
    checkOutput("rs_clkdiv", {16'd0, cmd_clkdiv}, 32'd124);
    card_type = 0; ready_after = 0; scenario_id = 7;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus();
    checkOutput("rs_restart_idx", {26'd0, cmd_idx}, 32'd0);
    checkOutput("rs_restart_pre", {16'd0, cmd_precycles}, 32'd80);
    waitEnd(2000);
    checkOutput("rs_done", {30'd0, init_done, init_err}, 32'd2);
    checkOutput("rs_first_idx", {26'd0, log_idx[0]}, 32'd0);
    checkOutput("rs_first_pre", {16'd0, log_pre[0]}, 32'd80);
    checkOutput("rs_ncmds", log_idx.size(), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
